nonrestoring_divider_16: RTL and testbench

Sequential 16-bit unsigned divider built on the reversible add/subtract operator. It runs the arithmetic in the inverse direction: it recovers quotient and remainder by repeated conditional add/subtract, with the operator's `r` select driven from the sign of the partial remainder each step. It sits beside the carry-skip operator in the arithmetic unit and uses valid/ready handshakes on both the operand side and the result side. Each division takes one iteration per quotient bit plus one correction cycle.

---
 rtl/nonrestoring_divider_16.sv | 170 +++++++++++++++++
 tb/tb_nonrestoring_divider_16.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/nonrestoring_divider_16.sv
// Sequential 16-bit unsigned non-restoring divider with valid/ready handshakes.
// One quotient bit per ITER cycle, then a single FIX cycle that corrects a negative partial remainder.
module nonrestoring_divider_16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   // state  | meaning
   // S_IDLE | waiting for operands, start_ready high
   // S_ITER | one shift plus add/subtract per cycle, cnt 0..15
   // S_FIX  | add D back if the final partial remainder is negative, load results
   // S_DONE | result held, out_valid high until out_ready
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH:0]   p_q, p_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic             accept;
   logic [WIDTH:0]   d_ext;
   logic [WIDTH:0]   p_shift;
   logic [WIDTH:0]   p_step;
   logic [WIDTH:0]   p_fix;

   assign accept  = (state_q == S_IDLE) && start_valid;
   assign d_ext   = {1'b0, d_q};
   assign p_shift = {p_q[WIDTH-1:0], a_q[WIDTH-1]};

   // The sign of the old partial remainder picks subtract (non-negative) or add (negative).
   always_comb begin
      p_step = p_shift - d_ext;
      if (p_q[WIDTH]) begin
         p_step = p_shift + d_ext;
      end
   end

   always_comb begin
      p_fix = p_q;
      if (p_q[WIDTH]) begin
         p_fix = p_q + d_ext;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         a_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         a_q     <= a_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               state_d = (divisor == '0) ? S_DONE : S_ITER;
            end
         end
         S_ITER: begin
            if (cnt_q == LAST_ITER) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      p_d   = p_q;
      a_d   = a_q;
      d_d   = d_q;
      cnt_d = cnt_q;
      quo_d = quo_q;
      rem_d = rem_q;
      dbz_d = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               p_d   = '0;
               a_d   = dividend;
               d_d   = divisor;
               cnt_d = '0;
               if (divisor == '0) begin
                  quo_d = '1;
                  rem_d = dividend;
                  dbz_d = 1'b1;
               end else begin
                  dbz_d = 1'b0;
               end
            end
         end
         S_ITER: begin
            p_d   = p_step;
            a_d   = {a_q[WIDTH-2:0], ~p_step[WIDTH]};
            cnt_d = cnt_q + 5'd1;
         end
         S_FIX: begin
            p_d   = p_fix;
            quo_d = a_q;
            rem_d = p_fix[WIDTH-1:0];
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      start_ready = 1'b0;
      out_valid   = 1'b0;
      case (state_q)
         S_IDLE:  start_ready = 1'b1;
         S_DONE:  out_valid   = 1'b1;
         default: begin
         end
      endcase
   end

   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider_16.sv
// Self-checking bench for nonrestoring_divider_16: directed vector table, handshake/reset
// corner sequences, and a randomized regression against a plain-arithmetic reference.
module tb_nonrestoring_divider_16;

   logic        clk;
   logic        rst;
   logic        start_valid;
   logic        start_ready;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int checks;
   int errors;

   nonrestoring_divider_16 #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] dd;
      logic [15:0] dv;
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer division, divide-by-zero returns all-ones and the dividend.
   task automatic ref_div(input logic [15:0] dd, input logic [15:0] dv,
                          output logic [15:0] q, output logic [15:0] r,
                          output logic dbz, output int lat);
      if (dv == 16'd0) begin
         q = 16'hFFFF; r = dd; dbz = 1'b1; lat = 1;
      end else begin
         q = dd / dv; r = dd % dv; dbz = 1'b0; lat = 18;
      end
   endtask

   // Issue one operation from IDLE, wait for out_valid, capture outputs, then drain the result.
   task automatic run_op(input logic [15:0] dd, input logic [15:0] dv,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dbz, output int lat);
      @(negedge clk);
      chk("start_ready_before_accept", {31'd0, start_ready}, 32'd1);
      start_valid = 1'b1;
      dividend    = dd;
      divisor     = dv;
      @(negedge clk);
      start_valid = 1'b0;
      dividend    = 16'($urandom);
      divisor     = 16'($urandom);
      chk("start_ready_after_accept", {31'd0, start_ready}, 32'd0);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
      end
      q   = quotient;
      r   = remainder;
      dbz = div_by_zero;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("idle_after_transfer_ready", {31'd0, start_ready}, 32'd1);
      chk("idle_after_transfer_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      logic [15:0] q, r, eq, er, dd, dv;
      logic        dbz, edbz;
      int          lat, elat;
      bit          saw_valid;

      checks = 0;
      errors = 0;

      vecs[0] = '{dd: 16'd100,   dv: 16'd7,     q: 16'd14,    r: 16'd2,  dbz: 1'b0, lat: 18};
      vecs[1] = '{dd: 16'hFFFF,  dv: 16'd1,     q: 16'hFFFF,  r: 16'd0,  dbz: 1'b0, lat: 18};
      vecs[2] = '{dd: 16'hFFFF,  dv: 16'hFFFF,  q: 16'd1,     r: 16'd0,  dbz: 1'b0, lat: 18};
      vecs[3] = '{dd: 16'd3,     dv: 16'd10,    q: 16'd0,     r: 16'd3,  dbz: 1'b0, lat: 18};
      vecs[4] = '{dd: 16'd5,     dv: 16'd0,     q: 16'hFFFF,  r: 16'd5,  dbz: 1'b1, lat: 1};
      vecs[5] = '{dd: 16'd9,     dv: 16'd3,     q: 16'd3,     r: 16'd0,  dbz: 1'b0, lat: 18};
      vecs[6] = '{dd: 16'd0,     dv: 16'd5,     q: 16'd0,     r: 16'd0,  dbz: 1'b0, lat: 18};
      vecs[7] = '{dd: 16'd40000, dv: 16'd40001, q: 16'd0,     r: 16'd40000, dbz: 1'b0, lat: 18};

      rst         = 1'b1;
      start_valid = 1'b0;
      out_ready   = 1'b0;
      dividend    = 16'd0;
      divisor     = 16'd0;
      repeat (2) @(negedge clk);
      chk("reset_start_ready", {31'd0, start_ready}, 32'd1);
      chk("reset_out_valid",   {31'd0, out_valid},   32'd0);
      chk("reset_quotient",    {16'd0, quotient},    32'd0);
      chk("reset_remainder",   {16'd0, remainder},   32'd0);
      chk("reset_div_by_zero", {31'd0, div_by_zero}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].dd, vecs[i].dv, q, r, dbz, lat);
         chk("vec_quotient",  {16'd0, q},   {16'd0, vecs[i].q});
         chk("vec_remainder", {16'd0, r},   {16'd0, vecs[i].r});
         chk("vec_dbz",       {31'd0, dbz}, {31'd0, vecs[i].dbz});
         chk("vec_latency",   32'(lat),     32'(vecs[i].lat));
      end

      // Back-pressure and ignored start_valid outside IDLE.
      @(negedge clk);
      start_valid = 1'b1;
      dividend    = 16'd1234;
      divisor     = 16'd56;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         start_valid = 1'b1;
         dividend    = 16'd999;
         divisor     = 16'd9;
         chk("iter_start_ready_low", {31'd0, start_ready}, 32'd0);
         @(negedge clk);
      end
      start_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("hold_reached_done", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         start_valid = 1'b1;
         dividend    = 16'd777;
         divisor     = 16'd0;
         chk("hold_out_valid",   {31'd0, out_valid},   32'd1);
         chk("hold_start_ready", {31'd0, start_ready}, 32'd0);
         chk("hold_quotient",    {16'd0, quotient},    32'd22);
         chk("hold_remainder",   {16'd0, remainder},   32'd2);
         chk("hold_dbz",         {31'd0, div_by_zero}, 32'd0);
         @(negedge clk);
      end
      start_valid = 1'b0;
      out_ready   = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("hold_released_idle", {31'd0, start_ready}, 32'd1);
      run_op(16'd60000, 16'd7, q, r, dbz, lat);
      chk("after_hold_quotient",  {16'd0, q}, 32'd8571);
      chk("after_hold_remainder", {16'd0, r}, 32'd3);

      // Reset in the middle of ITER after a divide-by-zero left non-zero outputs.
      run_op(16'd7, 16'd0, q, r, dbz, lat);
      chk("pre_reset_dbz", {31'd0, dbz}, 32'd1);
      @(negedge clk);
      start_valid = 1'b1;
      dividend    = 16'd500;
      divisor     = 16'd3;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midop_reset_start_ready", {31'd0, start_ready}, 32'd1);
      chk("midop_reset_out_valid",   {31'd0, out_valid},   32'd0);
      chk("midop_reset_quotient",    {16'd0, quotient},    32'd0);
      chk("midop_reset_remainder",   {16'd0, remainder},   32'd0);
      chk("midop_reset_dbz",         {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      chk("no_result_after_reset", {31'd0, saw_valid}, 32'd0);
      run_op(16'd100, 16'd7, q, r, dbz, lat);
      chk("post_reset_quotient",  {16'd0, q}, 32'd14);
      chk("post_reset_remainder", {16'd0, r}, 32'd2);

      // Randomized regression against the arithmetic reference.
      for (int n = 0; n < 3000; n++) begin
         dd = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       dv = 16'd0;
            1, 2:    dv = 16'($urandom_range(1, 15));
            3:       dv = 16'($urandom_range(256, 65535));
            4:       dv = dd;
            default: dv = 16'($urandom);
         endcase
         if (n % 97 == 0) dd = 16'hFFFF;
         ref_div(dd, dv, eq, er, edbz, elat);
         run_op(dd, dv, q, r, dbz, lat);
         chk("rand_quotient",  {16'd0, q},   {16'd0, eq});
         chk("rand_remainder", {16'd0, r},   {16'd0, er});
         chk("rand_dbz",       {31'd0, dbz}, {31'd0, edbz});
         chk("rand_latency",   32'(lat),     32'(elat));
         if (dv != 16'd0) begin
            chk("rand_invariant", 32'(q) * 32'(dv) + 32'(r), 32'(dd));
            chk("rand_rem_lt_div", {31'd0, (r < dv)}, 32'd1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
